// File: rtl/vga_readback_pkg.sv
// vga_readback shared constants: register map, STATUS layout, raster default.
// Imported by the interface, the edge detector and the top level.
package vga_readback_pkg;

    localparam int DEFAULT_VACTIVE = 480;
    localparam int DEFAULT_ADDR_W  = 5;

    localparam int ADDR_SNAP0  = 0;
    localparam int ADDR_SNAP1  = 1;
    localparam int ADDR_SNAP2  = 2;
    localparam int ADDR_STATUS = 3;
    localparam int ADDR_FRAME  = 4;
    localparam int ADDR_CTRL   = 5;

    localparam int STAT_VBLANK     = 0;
    localparam int STAT_PEND       = 1;
    localparam int STAT_VCOUNT_LSB = 16;

endpackage

// File: rtl/vga_readback_if.sv
// Avalon-MM slave bus bundle for vga_readback (fixed read latency of 1).
// master = host side, slave = peripheral side.
interface vga_readback_if #(
    parameter int ADDR_W = 5
) ();

    logic              chipselect;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output chipselect, read, write, address, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  chipselect, read, write, address, writedata,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/vga_readback_vblank_edge_detect.sv
// Registers the raster line and emits one pulse per frame, in the cycle
// after the line counter enters the first non-visible line.
module vblank_edge_detect
    import vga_readback_pkg::*;
#(
    parameter int VACTIVE = DEFAULT_VACTIVE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] vcount,
    output logic       pulse
);

    localparam logic [9:0] VLINE = 10'(VACTIVE);

    logic [9:0] prev;

    // prev resets to VLINE so a reset taken on that line cannot fire a pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            prev  <= VLINE;
            pulse <= 1'b0;
        end else begin
            prev  <= vcount;
            pulse <= (vcount == VLINE) && (prev != VLINE);
        end
    end

endmodule

// File: rtl/vga_readback.sv
// Read-side sprite peripheral: vblank snapshot, STATUS, FRAME, optional irq.
// Optional irq/CTRL logic is enabled by defining VGA_READBACK_IRQ_EN.
module vga_readback
    import vga_readback_pkg::*;
#(
    parameter int VACTIVE = DEFAULT_VACTIVE,
    parameter int ADDR_W  = DEFAULT_ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    vga_readback_if.slave bus,
    output logic        irq,
    input  logic [31:0] sprite1,
    input  logic [31:0] sprite2,
    input  logic [31:0] sprite3,
    input  logic [9:0]  VGA_VCOUNT,
    input  logic [9:0]  VGA_HCOUNT
);

    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              rd_en;
    logic              wr_en;
    logic              pulse;
    logic              vblank;

    logic [31:0] snap0;
    logic [31:0] snap1;
    logic [31:0] snap2;
    logic [31:0] frame;
    logic        pending;
    logic        enable;

    logic [31:0] status;
    logic [31:0] rd_word;
    logic [31:0] rdata;
    logic        rvalid;

    assign addr   = bus.address;
    assign word   = 32'(addr);
    assign rd_en  = bus.chipselect & bus.read;
    assign wr_en  = bus.chipselect & bus.write;
    assign vblank = VGA_VCOUNT >= 10'(VACTIVE);

    vblank_edge_detect #(
        .VACTIVE (VACTIVE)
    ) u_edge (
        .clk    (clk),
        .reset  (reset),
        .vcount (VGA_VCOUNT),
        .pulse  (pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            snap0 <= '0;
            snap1 <= '0;
            snap2 <= '0;
            frame <= '0;
        end else if (pulse) begin
            snap0 <= sprite1;
            snap1 <= sprite2;
            snap2 <= sprite3;
            frame <= frame + 32'd1;
        end
    end

`ifdef VGA_READBACK_IRQ_EN
    logic wr_status;
    logic wr_ctrl;
    logic unused_ok;

    assign wr_status = wr_en && (word == ADDR_STATUS);
    assign wr_ctrl   = wr_en && (word == ADDR_CTRL);
    assign unused_ok = ^{VGA_HCOUNT, bus.writedata[31:2]};

    // a clear landing on the pulse cycle loses to the new set
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            enable  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (pulse)
                pending <= 1'b1;
            else if (wr_status && bus.writedata[STAT_PEND])
                pending <= 1'b0;
            if (wr_ctrl)
                enable <= bus.writedata[0];
            irq <= pending & enable;
        end
    end
`else
    logic unused_ok;

    assign pending   = 1'b0;
    assign enable    = 1'b0;
    assign irq       = 1'b0;
    assign unused_ok = ^{VGA_HCOUNT, bus.writedata, wr_en};
`endif

    always_comb begin
        status = '0;
        status[STAT_VBLANK] = vblank;
        status[STAT_PEND]   = pending;
        status[STAT_VCOUNT_LSB +: 10] = VGA_VCOUNT;
    end

    always_comb begin
        rd_word = '0;
        case (word)
            ADDR_SNAP0:  rd_word = snap0;
            ADDR_SNAP1:  rd_word = snap1;
            ADDR_SNAP2:  rd_word = snap2;
            ADDR_STATUS: rd_word = status;
            ADDR_FRAME:  rd_word = frame;
            ADDR_CTRL:   rd_word = {31'd0, enable};
            default:     rd_word = '0;
        endcase
    end

    // mux samples pre-update state, so same-cycle writes/pulses read old values
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en)
                rdata <= rd_word;
        end
    end

    assign bus.readdata      = rdata;
    assign bus.readdatavalid = rvalid;

endmodule

// File: tb/tb_vga_readback.sv
// Directed self-checking bench for vga_readback.
// Covers reset, capture, FRAME wrap, back-to-back reads, irq or CTRL-off build.
module tb_vga_readback;

`ifdef VGA_READBACK_IRQ_EN
    localparam logic [31:0] PEND_BIT = 32'h2;
`else
    localparam logic [31:0] PEND_BIT = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        irq;
    logic [31:0] sprite1;
    logic [31:0] sprite2;
    logic [31:0] sprite3;
    logic [9:0]  vcount;
    logic [9:0]  hcount;

    int nvec = 0;
    int nbad = 0;

    vga_readback_if #(.ADDR_W(5)) bus ();

    vga_readback #(
        .VACTIVE (480),
        .ADDR_W  (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .irq        (irq),
        .sprite1    (sprite1),
        .sprite2    (sprite2),
        .sprite3    (sprite3),
        .VGA_VCOUNT (vcount),
        .VGA_HCOUNT (hcount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                      input string tag);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        tick();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        chk({tag, "_valid"}, {31'd0, bus.readdatavalid}, 32'd1);
        chk(tag, bus.readdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    // 479 -> 480, then one cycle of pulse and one for the update to land
    task automatic vblank_entry();
        vcount = 10'd479;
        tick();
        vcount = 10'd480;
        tick();
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        sprite1        = 32'h1234_5678;
        sprite2        = 32'hA5A5_0F0F;
        sprite3        = 32'h0000_0003;
        vcount         = 10'd0;
        hcount         = 10'd0;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_rdata", bus.readdata, 32'd0);
        chk("rst_rvalid", {31'd0, bus.readdatavalid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 6; a++) begin
            rd(5'(a), 32'd0, $sformatf("rst_read%0d", a));
            tick();
            chk($sformatf("rst_idle%0d", a),
                {31'd0, bus.readdatavalid}, 32'd0);
        end

        // capture: read FRAME during the pulse cycle sees the old value
        vcount = 10'd479;
        tick();
        vcount = 10'd480;
        tick();
        rd(5'd4, 32'd0, "frame_pre_update");
        vcount  = 10'd481;
        sprite1 = 32'hDEAD_BEEF;
        tick();
        rd(5'd0, 32'h1234_5678, "snap0");
        rd(5'd1, 32'hA5A5_0F0F, "snap1");
        rd(5'd2, 32'h0000_0003, "snap2");
        rd(5'd4, 32'd1, "frame_one");
        rd(5'd9, 32'd0, "unmapped");

        // back-to-back reads 0,4,3 during line 500
        vcount = 10'd500;
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 5'd0;
        tick();
        chk("b2b0_valid", {31'd0, bus.readdatavalid}, 32'd1);
        chk("b2b0", bus.readdata, 32'h1234_5678);
        bus.address = 5'd4;
        tick();
        chk("b2b4_valid", {31'd0, bus.readdatavalid}, 32'd1);
        chk("b2b4", bus.readdata, 32'd1);
        bus.address = 5'd3;
        tick();
        chk("b2b3_valid", {31'd0, bus.readdatavalid}, 32'd1);
        chk("b2b3", bus.readdata, 32'h01F4_0001 | PEND_BIT);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        tick();
        chk("b2b_idle", {31'd0, bus.readdatavalid}, 32'd0);
        chk("b2b_hold", bus.readdata, 32'h01F4_0001 | PEND_BIT);

        // FRAME wraps from all-ones to zero
        force dut.frame = 32'hFFFF_FFFF;
        #1;
        release dut.frame;
        rd(5'd4, 32'hFFFF_FFFF, "frame_preload");
        vblank_entry();
        rd(5'd4, 32'd0, "frame_wrap");
        rd(5'd0, 32'hDEAD_BEEF, "snap0_second");

`ifdef VGA_READBACK_IRQ_EN
        wr(5'd3, 32'h2);
        wr(5'd5, 32'h1);
        tick();
        chk("irq_idle", {31'd0, irq}, 32'd0);
        rd(5'd5, 32'd1, "ctrl_set");
        vcount = 10'd479;
        tick();
        vcount = 10'd480;
        tick();
        tick();
        tick();
        chk("irq_rise", {31'd0, irq}, 32'd1);
        wr(5'd3, 32'h2);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        tick();
        chk("irq_fall", {31'd0, irq}, 32'd0);
        // clear on the pulse cycle
        vcount = 10'd479;
        tick();
        vcount = 10'd480;
        tick();
        wr(5'd3, 32'h2);
        rd(5'd3, 32'h01E0_0003, "set_beats_clear");
        // read and write together: read returns the old CTRL
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 5'd5;
        bus.writedata  = 32'd0;
        tick();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        chk("rw_old_ctrl", bus.readdata, 32'd1);
        rd(5'd5, 32'd0, "ctrl_cleared");
        tick();
        chk("irq_disabled", {31'd0, irq}, 32'd0);
`else
        wr(5'd5, 32'h1);
        rd(5'd5, 32'd0, "ctrl_off");
        vblank_entry();
        tick();
        chk("irq_off", {31'd0, irq}, 32'd0);
        rd(5'd3, 32'h01E0_0001, "status_no_pend");
`endif

        // reset while sitting on line 480: no pulse until re-entry
        vcount = 10'd480;
        reset  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        rd(5'd4, 32'd0, "rst480_frame");
        rd(5'd0, 32'd0, "rst480_snap");
        chk("rst480_irq", {31'd0, irq}, 32'd0);
        vcount = 10'd481;
        tick();
        vcount = 10'd480;
        tick();
        tick();
        rd(5'd4, 32'd1, "reentry_frame");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
